// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the coprocessor-1 datapaths.
//
// Contents:
//   FP_BIAS          single-precision exponent bias
//   FP_EXP_SPECIAL   biased exponent of NaN / infinity
//   INT_MAX/INT_MIN  32-bit two's-complement limits
//   FP_NEG_2_31      encoding of -2^31, the only e = 31 value that converts
//   cvt_state_t      state encoding of the float-to-int converter
package fp_pkg;

  localparam int unsigned FP_BIAS        = 127;
  localparam logic [7:0]  FP_EXP_SPECIAL = 8'hFF;
  localparam logic [31:0] INT_MAX        = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN        = 32'h8000_0000;
  localparam logic [31:0] FP_NEG_2_31    = 32'hCF00_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIX   = 2'd2
  } cvt_state_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational unpacker for an IEEE-754 single-precision operand.
// Splits the fields and classifies the value for the converter and the
// add/sub path.
//
// Ports:
//   float_in   in   32  operand
//   sign       out  1   sign bit
//   frac       out  23  fraction field (hidden bit not included)
//   exp_unb    out  9   signed unbiased exponent e = E - 127
//   zero       out  1   +0 or -0
//   special    out  1   NaN or infinity (E = 255)
//   too_large  out  1   finite, e >= 31, and not exactly -2^31
//   exact_min  out  1   operand is exactly -2^31
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]       float_in,
  output logic              sign,
  output logic [22:0]       frac,
  output logic signed [8:0] exp_unb,
  output logic              zero,
  output logic              special,
  output logic              too_large,
  output logic              exact_min
);

  logic [7:0] exp_biased;

  assign sign       = float_in[31];
  assign exp_biased = float_in[30:23];
  assign frac       = float_in[22:0];

  // Modular 9-bit subtraction, reinterpreted as signed: range -127..128.
  assign exp_unb    = signed'({1'b0, exp_biased} - 9'(FP_BIAS));

  assign zero       = (float_in[30:0] == 31'd0);
  assign special    = (exp_biased == FP_EXP_SPECIAL);
  assign exact_min  = (float_in == FP_NEG_2_31);
  assign too_large  = !special && !exact_min && (exp_unb >= 9'sd31);

endmodule

// File: rtl/fp_to_int_converter.sv
// Multi-cycle IEEE-754 single -> 32-bit signed integer converter
// (cvt.w.s / trunc.w.s). The significand is denormalized one bit per cycle,
// optionally rounded, then sign-applied and registered.
//
// Configuration macro:
//   FP_CVT_ROUND_NEAREST_EN  defined   -> round to nearest, ties to even
//                            undefined -> truncate toward zero
//   Latency is the same in both builds.
//
// Ports:
//   clk       in   1   clock, rising edge
//   reset     in   1   synchronous, active-high
//   start     in   1   request a conversion (sampled only when idle)
//   float_in  in   32  operand, captured on the accepting edge
//   busy      out  1   conversion in flight
//   done      out  1   one-cycle pulse: int_out / invalid are fresh
//   int_out   out  32  signed result, held until the next done
//   invalid   out  1   NaN, infinity or out of range, held with int_out
module fp_to_int_converter
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] float_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] int_out,
  output logic        invalid
);

  logic              u_sign;
  logic [22:0]       u_frac;
  logic signed [8:0] u_exp;
  logic              u_zero;
  logic              u_special;
  logic              u_too_large;
  logic              u_exact_min;

  fp_unpack u_unpack (
    .float_in  (float_in),
    .sign      (u_sign),
    .frac      (u_frac),
    .exp_unb   (u_exp),
    .zero      (u_zero),
    .special   (u_special),
    .too_large (u_too_large),
    .exact_min (u_exact_min)
  );

  cvt_state_t  state;
  logic [4:0]  count;
  logic [31:0] mag;
  logic        sign_r;
  logic        left_r;
  logic        inv_r;
`ifdef FP_CVT_ROUND_NEAREST_EN
  logic        guard;
  logic        sticky;
`endif

  logic        accept;
  logic [31:0] load_mag;
  logic [4:0]  load_count;
  logic        load_sign;
  logic        load_left;
  logic        load_invalid;
  logic        load_sticky;
  logic [31:0] rounded;
  logic [31:0] result;

  assign accept = (state == IDLE) && start;

  // Classification at the accepting edge.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    load_mag     = {8'd0, 1'b1, u_frac};
    load_count   = 5'd0;
    load_sign    = u_sign;
    load_left    = 1'b0;
    load_invalid = 1'b0;
    load_sticky  = 1'b0;
    if (u_special || u_too_large) begin
      load_invalid = 1'b1;
      load_mag     = '0;
    end else if (u_exact_min) begin
      // Negating 0x80000000 yields itself, so FIX produces INT_MIN directly.
      load_mag  = INT_MIN;
      load_sign = 1'b1;
    end else if (u_zero || u_exp < -9'sd1) begin
      // Below 0.5 in magnitude: integer part is zero, only stickiness remains.
      load_mag    = '0;
      load_sticky = !u_zero;
    end else if (u_exp <= 9'sd23) begin
      load_count = 5'(9'sd23 - u_exp);
    end else begin
      load_count = 5'(u_exp - 9'sd23);
      load_left  = 1'b1;
    end
  end

  always_comb begin
`ifdef FP_CVT_ROUND_NEAREST_EN
    // Round up when above half, or exactly half with an odd LSB.
    rounded = mag + {31'd0, guard & (sticky | mag[0])};
`else
    rounded = mag;
`endif
    result = sign_r ? (~rounded + 32'd1) : rounded;
  end

  // Control and visible outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      int_out <= '0;
      invalid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= (load_count != 5'd0) ? SHIFT : FIX;
          end
        end
        SHIFT: begin
          if (count == 5'd1) state <= FIX;
        end
        FIX: begin
          int_out <= inv_r ? INT_MAX : result;
          invalid <= inv_r;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the shift datapath has no reset; it is always loaded on the
  // accepting edge before any of it is observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      mag    <= load_mag;
      count  <= load_count;
      sign_r <= load_sign;
      left_r <= load_left;
      inv_r  <= load_invalid;
`ifdef FP_CVT_ROUND_NEAREST_EN
      guard  <= 1'b0;
      sticky <= load_sticky;
`endif
    end else if (state == SHIFT) begin
      count <= count - 5'd1;
      if (left_r) begin
        mag <= {mag[30:0], 1'b0};
      end else begin
        mag <= {1'b0, mag[31:1]};
`ifdef FP_CVT_ROUND_NEAREST_EN
        guard  <= mag[0];
        sticky <= sticky | guard;
`endif
      end
    end
  end

`ifndef FP_CVT_ROUND_NEAREST_EN
  // Sticky information is irrelevant when truncating.
  logic unused_sticky;
  assign unused_sticky = load_sticky;
`endif

endmodule
